// File: rtl/llr_hard_decision_packer.sv
// Hard-decision slicer and LSB-first bit packer for framed LLR streams, with frame-length checking.
// Optional HDP_ONES_COUNT_EN adds ones_cnt: the number of 1 bits in the last good frame.
module llr_hard_decision_packer #(
    parameter int LLR_W      = 16,
    parameter int OUT_W      = 32,
    parameter int MAX_BLKLEN = 6144,
    parameter int BLKLEN_W   = 13
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic [BLKLEN_W-1:0] blklen,
    input  logic [LLR_W-1:0]    s_axis_llr_tdata,
    input  logic                s_axis_llr_tvalid,
    output logic                s_axis_llr_tready,
    input  logic                s_axis_llr_tuser,
    input  logic                s_axis_llr_tlast,
    output logic [OUT_W-1:0]    m_axis_bits_tdata,
    output logic                m_axis_bits_tvalid,
    input  logic                m_axis_bits_tready,
    output logic                m_axis_bits_tlast,
    output logic                frame_err,
    output logic [1:0]          err_code,
    output logic [15:0]         frame_cnt
`ifdef HDP_ONES_COUNT_EN
    ,
    output logic [BLKLEN_W-1:0] ones_cnt
`endif
);

    localparam int WB_W = $clog2(OUT_W);
    localparam logic [BLKLEN_W-1:0] MAX_BLK  = BLKLEN_W'(MAX_BLKLEN);
    localparam logic [BLKLEN_W-1:0] ONE_BLK  = BLKLEN_W'(1);
    localparam logic [WB_W-1:0]     LAST_BIT = WB_W'(OUT_W - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DROP} state_t;

    state_t              state, n_state;
    logic [OUT_W-1:0]    shreg, n_shreg, word, word0, emit_data;
    logic [WB_W-1:0]     wbit, n_wbit;
    logic [BLKLEN_W-1:0] bit_cnt, n_bit_cnt, blk_q, n_blk, cnt1;
    logic                flush_pend, n_flush, rdy_en;
    logic                accept, hb, sof_ok, do_start;
    logic                emit, emit_last, err_set, fc_inc, frame_start, frame_bit;
    logic [1:0]          err_val;
    logic                unused_llr;

    assign hb         = s_axis_llr_tdata[LLR_W-1];
    assign unused_llr = ^s_axis_llr_tdata[LLR_W-2:0];
    assign s_axis_llr_tready = rdy_en && !flush_pend &&
                               ((state == DROP) || !(m_axis_bits_tvalid && !m_axis_bits_tready));
    assign accept = s_axis_llr_tvalid && s_axis_llr_tready;
    assign word   = shreg | (OUT_W'(hb) << wbit);
    assign word0  = OUT_W'(hb);
    assign cnt1   = bit_cnt + ONE_BLK;
    assign sof_ok = (blklen != '0) && (blklen <= MAX_BLK);

    always_comb begin
        n_state     = state;
        n_shreg     = shreg;
        n_wbit      = wbit;
        n_bit_cnt   = bit_cnt;
        n_blk       = blk_q;
        n_flush     = flush_pend;
        emit        = 1'b0;
        emit_data   = '0;
        emit_last   = 1'b0;
        err_set     = 1'b0;
        err_val     = 2'd0;
        fc_inc      = 1'b0;
        frame_start = 1'b0;
        frame_bit   = 1'b0;
        do_start    = 1'b0;

        // A SOF that aborts a frame and is itself complete leaves its word parked here
        if (flush_pend && (!m_axis_bits_tvalid || m_axis_bits_tready)) begin
            emit      = 1'b1;
            emit_data = shreg;
            emit_last = 1'b1;
            n_shreg   = '0;
            n_flush   = 1'b0;
        end

        if (accept) begin
            case (state)
                IDLE: begin
                    if (s_axis_llr_tuser) begin
                        do_start = 1'b1;
                    end else begin
                        err_set = 1'b1;
                        err_val = 2'd3;
                        n_state = s_axis_llr_tlast ? IDLE : DROP;
                    end
                end
                COLLECT: begin
                    if (s_axis_llr_tuser) begin
                        emit      = 1'b1;
                        emit_data = shreg;
                        emit_last = 1'b1;
                        err_set   = 1'b1;
                        err_val   = 2'd1;
                        do_start  = 1'b1;
                    end else begin
                        frame_bit = 1'b1;
                        n_bit_cnt = cnt1;
                        if (s_axis_llr_tlast || (cnt1 == blk_q)) begin
                            emit      = 1'b1;
                            emit_data = word;
                            emit_last = 1'b1;
                            n_shreg   = '0;
                            n_wbit    = '0;
                            n_bit_cnt = '0;
                            if (!s_axis_llr_tlast) begin
                                err_set = 1'b1;
                                err_val = 2'd2;
                                n_state = DROP;
                            end else begin
                                n_state = IDLE;
                                if (cnt1 == blk_q) begin
                                    fc_inc = 1'b1;
                                end else begin
                                    err_set = 1'b1;
                                    err_val = 2'd1;
                                end
                            end
                        end else if (wbit == LAST_BIT) begin
                            emit      = 1'b1;
                            emit_data = word;
                            n_shreg   = '0;
                            n_wbit    = '0;
                        end else begin
                            n_shreg = word;
                            n_wbit  = wbit + WB_W'(1);
                        end
                    end
                end
                DROP: begin
                    if (s_axis_llr_tlast) n_state = IDLE;
                end
                default: n_state = IDLE;
            endcase
        end

        if (do_start) begin
            n_blk     = blklen;
            n_shreg   = '0;
            n_wbit    = '0;
            n_bit_cnt = '0;
            if (!sof_ok) begin
                err_set = 1'b1;
                err_val = 2'd3;
                n_state = s_axis_llr_tlast ? IDLE : DROP;
            end else if (s_axis_llr_tlast || (blklen == ONE_BLK)) begin
                frame_bit   = 1'b1;
                frame_start = 1'b1;
                n_state     = s_axis_llr_tlast ? IDLE : DROP;
                if (s_axis_llr_tlast && (blklen == ONE_BLK)) begin
                    fc_inc = 1'b1;
                end else begin
                    err_set = 1'b1;
                    err_val = s_axis_llr_tlast ? 2'd1 : 2'd2;
                end
                if (state == COLLECT) begin
                    n_shreg = word0;
                    n_flush = 1'b1;
                end else begin
                    emit      = 1'b1;
                    emit_data = word0;
                    emit_last = 1'b1;
                end
            end else begin
                frame_bit   = 1'b1;
                frame_start = 1'b1;
                n_shreg     = word0;
                n_wbit      = WB_W'(1);
                n_bit_cnt   = ONE_BLK;
                n_state     = COLLECT;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state              <= IDLE;
            shreg              <= '0;
            wbit               <= '0;
            bit_cnt            <= '0;
            blk_q              <= '0;
            flush_pend         <= 1'b0;
            rdy_en             <= 1'b0;
            m_axis_bits_tdata  <= '0;
            m_axis_bits_tvalid <= 1'b0;
            m_axis_bits_tlast  <= 1'b0;
            frame_err          <= 1'b0;
            err_code           <= 2'd0;
            frame_cnt          <= '0;
        end else begin
            state      <= n_state;
            shreg      <= n_shreg;
            wbit       <= n_wbit;
            bit_cnt    <= n_bit_cnt;
            blk_q      <= n_blk;
            flush_pend <= n_flush;
            rdy_en     <= 1'b1;
            if (emit) begin
                m_axis_bits_tvalid <= 1'b1;
                m_axis_bits_tdata  <= emit_data;
                m_axis_bits_tlast  <= emit_last;
            end else if (m_axis_bits_tready) begin
                m_axis_bits_tvalid <= 1'b0;
            end
            frame_err <= err_set;
            if (err_set) err_code <= err_val;
            if (fc_inc) frame_cnt <= frame_cnt + 16'd1;
        end
    end

`ifdef HDP_ONES_COUNT_EN
    logic [BLKLEN_W-1:0] ones_acc, ones_base;
    assign ones_base = frame_start ? '0 : ones_acc;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ones_acc <= '0;
            ones_cnt <= '0;
        end else begin
            if (frame_bit) ones_acc <= ones_base + BLKLEN_W'(hb);
            if (fc_inc)    ones_cnt <= ones_base + BLKLEN_W'(hb);
        end
    end
`else
    logic unused_ones;
    assign unused_ones = frame_start ^ frame_bit;
`endif

endmodule

// File: tb/tb_llr_hard_decision_packer.sv
// Scoreboard bench for llr_hard_decision_packer: a frame-level bit-queue model predicts words and errors.
module tb_llr_hard_decision_packer;

    localparam int LLR_W      = 16;
    localparam int OUT_W      = 32;
    localparam int MAX_BLKLEN = 6144;
    localparam int BLKLEN_W   = 13;

    logic                aclk = 1'b0;
    logic                aresetn;
    logic [BLKLEN_W-1:0] blklen;
    logic [LLR_W-1:0]    s_axis_llr_tdata;
    logic                s_axis_llr_tvalid, s_axis_llr_tready, s_axis_llr_tuser, s_axis_llr_tlast;
    logic [OUT_W-1:0]    m_axis_bits_tdata;
    logic                m_axis_bits_tvalid, m_axis_bits_tready, m_axis_bits_tlast;
    logic                frame_err;
    logic [1:0]          err_code;
    logic [15:0]         frame_cnt;

    llr_hard_decision_packer #(
        .LLR_W(LLR_W), .OUT_W(OUT_W), .MAX_BLKLEN(MAX_BLKLEN), .BLKLEN_W(BLKLEN_W)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .blklen(blklen),
        .s_axis_llr_tdata(s_axis_llr_tdata), .s_axis_llr_tvalid(s_axis_llr_tvalid),
        .s_axis_llr_tready(s_axis_llr_tready), .s_axis_llr_tuser(s_axis_llr_tuser),
        .s_axis_llr_tlast(s_axis_llr_tlast),
        .m_axis_bits_tdata(m_axis_bits_tdata), .m_axis_bits_tvalid(m_axis_bits_tvalid),
        .m_axis_bits_tready(m_axis_bits_tready), .m_axis_bits_tlast(m_axis_bits_tlast),
        .frame_err(frame_err), .err_code(err_code), .frame_cnt(frame_cnt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [OUT_W-1:0] d;
        logic             l;
    } word_t;

    int    checks = 0;
    int    errors = 0;
    word_t expq[$];
    int    errq[$];
    bit    mbits[$];
    int    m_mode = 0;   // 0 idle, 1 in frame, 2 dropping
    int    m_n    = 0;
    int    m_blk  = 0;
    int    m_fcnt = 0;
    int    rdy_mode = 0;
    bit    exp_rdy  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void push_word(input bit last);
        word_t w;
        w.d = '0;
        foreach (mbits[i]) w.d[i] = mbits[i];
        w.l = last;
        expq.push_back(w);
        mbits.delete();
    endfunction

    function automatic int model_add(input bit b, input bit tl);
        mbits.push_back(b);
        m_n++;
        if (tl) begin
            push_word(1'b1);
            m_mode = 0;
            if (m_n == m_blk) begin
                m_fcnt++;
                return 0;
            end
            return 1;
        end
        if (m_n == m_blk) begin
            push_word(1'b1);
            m_mode = 2;
            return 2;
        end
        if (mbits.size() == OUT_W) push_word(1'b0);
        return 0;
    endfunction

    function automatic void model_beat(input bit u, input bit tl, input logic signed [LLR_W-1:0] d, input int blk);
        bit b = (d < 0);
        int err = 0;
        int e;
        bit start = 1'b0;
        case (m_mode)
            0: if (u) start = 1'b1; else begin err = 3; m_mode = tl ? 0 : 2; end
            1: if (u) begin push_word(1'b1); err = 1; start = 1'b1; end
               else err = model_add(b, tl);
            default: if (tl) m_mode = 0;
        endcase
        if (start) begin
            m_blk = blk;
            m_n   = 0;
            mbits.delete();
            if (blk == 0 || blk > MAX_BLKLEN) begin
                err    = 3;
                m_mode = tl ? 0 : 2;
            end else begin
                m_mode = 1;
                e = model_add(b, tl);
                if (e != 0) err = e;
            end
        end
        if (err != 0) errq.push_back(err);
    endfunction

    // Call at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic send(input bit u, input bit tl, input logic [LLR_W-1:0] d);
        bit ok = 1'b0;
        s_axis_llr_tvalid = 1'b1;
        s_axis_llr_tuser  = u;
        s_axis_llr_tlast  = tl;
        s_axis_llr_tdata  = d;
        for (int unsigned w = 0; w < 2000 && !ok; w++) begin
            @(negedge aclk);
            if (exp_rdy && w == 0) chk("drop_tready", 64'(s_axis_llr_tready), 64'd1);
            if (s_axis_llr_tready) begin
                ok = 1'b1;
                model_beat(u, tl, d, int'(blklen));
            end
            @(posedge aclk);
            #1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=tready_low required=accept t=%0t", $time);
        end
        s_axis_llr_tvalid = 1'b0;
        s_axis_llr_tuser  = 1'b0;
        s_axis_llr_tlast  = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int unsigned w = 0; w < 3000 && !done; w++) begin
            @(posedge aclk);
            #1;
            if (expq.size() == 0 && !m_axis_bits_tvalid) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_words_pending required=0", expq.size());
        end
        repeat (3) @(posedge aclk);
        #1;
        chk("err_pending", 64'(errq.size()), 64'd0);
        chk("frame_cnt", 64'(frame_cnt), 64'(m_fcnt & 16'hFFFF));
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_n    = 0;
        m_fcnt = 0;
        mbits.delete();
        expq.delete();
        errq.delete();
    endtask

    function automatic logic [LLR_W-1:0] rnd_llr();
        if ($urandom_range(0, 9) == 0) return '0;
        return LLR_W'($urandom);
    endfunction

    // Downstream ready generator
    initial begin
        m_axis_bits_tready = 1'b1;
        forever begin
            @(posedge aclk);
            #1;
            case (rdy_mode)
                0:       m_axis_bits_tready = 1'b1;
                1:       m_axis_bits_tready = ~m_axis_bits_tready;
                default: m_axis_bits_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: pops expected words and errors as the DUT presents them
    initial begin
        bit               prev_stall = 1'b0;
        logic [OUT_W-1:0] prev_d = '0;
        logic             prev_l = 1'b0;
        word_t            w;
        int               ec;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                prev_stall = 1'b0;
            end else begin
                if (frame_err) begin
                    if (errq.size() == 0) begin
                        chk("err_unexpected", 64'(err_code), 64'd0);
                        if (err_code == 2'd0) begin
                            errors++;
                            $display("FAIL err_unexpected actual=pulse required=no_pulse");
                        end
                    end else begin
                        ec = errq.pop_front();
                        chk("err_code", 64'(err_code), 64'(ec));
                    end
                end
                if (m_axis_bits_tvalid) begin
                    if (prev_stall) begin
                        chk("stall_tdata", 64'(m_axis_bits_tdata), 64'(prev_d));
                        chk("stall_tlast", 64'(m_axis_bits_tlast), 64'(prev_l));
                    end
                    if (m_axis_bits_tready) begin
                        if (expq.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL word_unexpected actual=%0h required=none", m_axis_bits_tdata);
                        end else begin
                            w = expq.pop_front();
                            chk("word_tdata", 64'(m_axis_bits_tdata), 64'(w.d));
                            chk("word_tlast", 64'(m_axis_bits_tlast), 64'(w.l));
                        end
                    end
                end
                prev_stall = m_axis_bits_tvalid && !m_axis_bits_tready;
                prev_d     = m_axis_bits_tdata;
                prev_l     = m_axis_bits_tlast;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        int blk, len, cut;
        bit abort;
        aresetn           = 1'b0;
        blklen            = '0;
        s_axis_llr_tdata  = '0;
        s_axis_llr_tvalid = 1'b0;
        s_axis_llr_tuser  = 1'b0;
        s_axis_llr_tlast  = 1'b0;

        repeat (3) @(negedge aclk);
        chk("rst_tready", 64'(s_axis_llr_tready), 64'd0);
        chk("rst_tvalid", 64'(m_axis_bits_tvalid), 64'd0);
        chk("rst_tdata", 64'(m_axis_bits_tdata), 64'd0);
        chk("rst_tlast", 64'(m_axis_bits_tlast), 64'd0);
        chk("rst_frame_err", 64'(frame_err), 64'd0);
        chk("rst_err_code", 64'(err_code), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        aresetn = 1'b1;
        #1;
        chk("tready_before_clk", 64'(s_axis_llr_tready), 64'd0);
        @(posedge aclk);
        #1;
        chk("tready_after_clk", 64'(s_axis_llr_tready), 64'd1);

        // 40-bit frame of alternating +5/-5
        blklen = BLKLEN_W'(40);
        for (int i = 0; i < 40; i++)
            send(i == 0, i == 39, (i % 2 == 0) ? 16'sd5 : -16'sd5);
        drain();

        // 64 ones with a toggling downstream ready
        rdy_mode = 1;
        blklen = BLKLEN_W'(64);
        for (int i = 0; i < 64; i++) send(i == 0, i == 63, 16'hFFFF);
        drain();

        // Short frame
        rdy_mode = 0;
        blklen = BLKLEN_W'(10);
        for (int i = 0; i < 6; i++) send(i == 0, i == 5, rnd_llr());
        drain();
        chk("short_err_code", 64'(err_code), 64'd1);

        // Long frame, tail absorbed, then a clean frame
        rdy_mode = 2;
        blklen = BLKLEN_W'(8);
        for (int i = 0; i < 12; i++) begin
            exp_rdy = (i >= 8);
            send(i == 0, i == 11, rnd_llr());
        end
        exp_rdy = 1'b0;
        drain();
        chk("long_err_code", 64'(err_code), 64'd2);
        for (int i = 0; i < 8; i++) send(i == 0, i == 7, rnd_llr());
        drain();

        // Bad lengths and missing SOF
        blklen = '0;
        for (int i = 0; i < 3; i++) send(i == 0, i == 2, rnd_llr());
        send(1'b1, 1'b1, rnd_llr());
        blklen = BLKLEN_W'(7000);
        for (int i = 0; i < 3; i++) send(i == 0, i == 2, rnd_llr());
        blklen = BLKLEN_W'(5);
        for (int i = 0; i < 3; i++) send(1'b0, i == 2, rnd_llr());
        drain();
        chk("badlen_err_code", 64'(err_code), 64'd3);

        // One-bit frames and mid-frame SOF, including the parked-word case
        blklen = BLKLEN_W'(1);
        send(1'b1, 1'b1, 16'h8000);
        blklen = BLKLEN_W'(2);
        send(1'b1, 1'b1, 16'h0001);
        blklen = BLKLEN_W'(20);
        for (int i = 0; i < 10; i++) send(i == 0, 1'b0, rnd_llr());
        blklen = BLKLEN_W'(5);
        for (int i = 0; i < 5; i++) send(i == 0, i == 4, rnd_llr());
        blklen = BLKLEN_W'(40);
        for (int i = 0; i < 32; i++) send(i == 0, 1'b0, 16'hFFFF);
        blklen = BLKLEN_W'(1);
        send(1'b1, 1'b1, 16'hFFFF);
        drain();

        // Reset in the middle of a frame
        rdy_mode = 0;
        blklen = BLKLEN_W'(40);
        for (int i = 0; i < 17; i++) send(i == 0, 1'b0, 16'hFFFF);
        #2;
        aresetn = 1'b0;
        model_reset();
        @(negedge aclk);
        chk("midrst_tvalid", 64'(m_axis_bits_tvalid), 64'd0);
        chk("midrst_tready", 64'(s_axis_llr_tready), 64'd0);
        chk("midrst_frame_cnt", 64'(frame_cnt), 64'd0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        blklen = BLKLEN_W'(32);
        for (int i = 0; i < 32; i++) send(i == 0, i == 31, rnd_llr());
        drain();

        // Random frames
        rdy_mode = 2;
        for (int f = 0; f < 150; f++) begin
            cut = $urandom_range(0, 99);
            if (cut < 5)       blk = 0;
            else if (cut < 8)  blk = 7000;
            else               blk = $urandom_range(1, 70);
            if (blk == 0 || blk > MAX_BLKLEN) len = $urandom_range(1, 4);
            else begin
                len = blk + $urandom_range(0, 6) - 3;
                if (len < 1) len = 1;
            end
            abort = ($urandom_range(0, 9) == 0) && (f != 149);
            if ($urandom_range(0, 14) == 0) send(1'b0, 1'($urandom_range(0, 1)), rnd_llr());
            for (int i = 0; i < len; i++) begin
                blklen = (i == 0) ? BLKLEN_W'(blk) : BLKLEN_W'($urandom_range(0, 8191));
                send(i == 0, (i == len - 1) && !abort, rnd_llr());
            end
        end
        send(1'b0, 1'b1, rnd_llr());
        drain();
        chk("final_words_pending", 64'(expq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
